// File: rtl/xcorr_lag_engine_if.sv
// Control, sample-stream and result bundle between xcorr_lag_engine and its
// producer / peak-finder neighbours.
interface xcorr_lag_engine_if #(
  parameter int NUM_BITS_SAMPLE = 12,
  parameter int NUM_BITS_XCORRS = 34,
  parameter int MAX_LAGS        = 17
);
  localparam int NUM_LAGS = 2 * MAX_LAGS + 1;
  localparam int ITER_W   = $clog2(NUM_LAGS);

  logic                                           start;
  logic                                           busy;
  logic                                           s_valid;
  logic                                           s_ready;
  logic signed [NUM_BITS_SAMPLE-1:0]              s_a;
  logic signed [NUM_BITS_SAMPLE-1:0]              s_b;
  logic signed [NUM_LAGS-1:0][NUM_BITS_XCORRS-1:0] xcorr_out;
  logic        [ITER_W-1:0]                       iterator;
  logic                                           iter_valid;
  logic                                           frame_done;

  modport master (
    output start, s_valid, s_a, s_b,
    input  busy, s_ready, xcorr_out, iterator, iter_valid, frame_done
  );

  modport slave (
    input  start, s_valid, s_a, s_b,
    output busy, s_ready, xcorr_out, iterator, iter_valid, frame_done
  );
endinterface

// File: rtl/xcorr_lag_engine.sv
// Streaming cross-correlator: accumulates all 2*MAX_LAGS+1 lags of one frame in
// parallel, then presents the frozen result vector with a one-pass lag sweep.
module xcorr_lag_engine #(
  parameter int NUM_BITS_SAMPLE = 12,
  parameter int NUM_SAMPLES     = 1024,
  parameter int NUM_BITS_XCORRS = 34,
  parameter int MAX_LAGS        = 17
) (
  input logic               clk,
  input logic               rst,
  xcorr_lag_engine_if.slave bus
);
  localparam int NUM_LAGS = 2 * MAX_LAGS + 1;
  localparam int ITER_W   = $clog2(NUM_LAGS);
  localparam int CNT_W    = $clog2(NUM_SAMPLES);
  localparam int DRN_W    = $clog2(MAX_LAGS + 1);
  localparam int PROD_W   = 2 * NUM_BITS_SAMPLE;
  localparam int EXT_W    = NUM_BITS_XCORRS - PROD_W;

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_SCAN, S_DONE} state_t;

  state_t                             state_q, state_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [DRN_W-1:0]                   drn_q, drn_d;
  logic [ITER_W-1:0]                  iter_q, iter_d;
  logic                               clear, shift, load;
  logic signed [NUM_BITS_SAMPLE-1:0]  in_a, in_b;

  logic signed [NUM_BITS_SAMPLE-1:0]  a_line_q [MAX_LAGS];
  logic signed [NUM_BITS_SAMPLE-1:0]  b_line_q [2*MAX_LAGS];
  logic signed [NUM_BITS_SAMPLE-1:0]  b_tap    [NUM_LAGS];
  logic signed [PROD_W-1:0]           prod_d   [NUM_LAGS];
  logic signed [PROD_W-1:0]           prod_q   [NUM_LAGS];
  logic                               prod_en_q;
  logic signed [NUM_BITS_XCORRS-1:0]  acc_d    [NUM_LAGS];
  logic signed [NUM_BITS_XCORRS-1:0]  acc_q    [NUM_LAGS];
  logic [NUM_LAGS-1:0][NUM_BITS_XCORRS-1:0] xcorr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    iter_d  = iter_q;
    clear   = 1'b0;
    shift   = 1'b0;
    load    = 1'b0;
    in_a    = '0;
    in_b    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          clear   = 1'b1;
          cnt_d   = '0;
          drn_d   = '0;
          iter_d  = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (bus.s_valid) begin
          shift = 1'b1;
          in_a  = bus.s_a;
          in_b  = bus.s_b;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NUM_SAMPLES - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // MAX_LAGS zero shifts flush the lines, one more cycle empties the product stage
        if (drn_q == DRN_W'(MAX_LAGS)) begin
          load    = 1'b1;
          state_d = S_SCAN;
        end else begin
          shift = 1'b1;
          drn_d = drn_q + 1'b1;
        end
      end
      S_SCAN: begin
        if (iter_q == ITER_W'(NUM_LAGS - 1)) begin
          iter_d  = '0;
          state_d = S_DONE;
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Tap 0 is the sample arriving this cycle, so b_line_q only stores taps 1..2*MAX_LAGS.
  always_comb begin
    b_tap[0] = in_b;
    for (int unsigned j = 1; j < NUM_LAGS; j++) b_tap[j] = b_line_q[j-1];
    for (int unsigned j = 0; j < NUM_LAGS; j++) begin
      prod_d[j] = a_line_q[MAX_LAGS-1] * b_tap[j];
      acc_d[j]  = prod_en_q ? acc_q[j] + {{EXT_W{prod_q[j][PROD_W-1]}}, prod_q[j]}
                            : acc_q[j];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      drn_q     <= '0;
      iter_q    <= '0;
      prod_en_q <= 1'b0;
      xcorr_q   <= '0;
      for (int unsigned k = 0; k < MAX_LAGS; k++)   a_line_q[k] <= '0;
      for (int unsigned k = 0; k < 2*MAX_LAGS; k++) b_line_q[k] <= '0;
      for (int unsigned j = 0; j < NUM_LAGS; j++) begin
        prod_q[j] <= '0;
        acc_q[j]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drn_q     <= drn_d;
      iter_q    <= iter_d;
      prod_en_q <= shift;
      if (clear) begin
        for (int unsigned k = 0; k < MAX_LAGS; k++)   a_line_q[k] <= '0;
        for (int unsigned k = 0; k < 2*MAX_LAGS; k++) b_line_q[k] <= '0;
        for (int unsigned j = 0; j < NUM_LAGS; j++) begin
          prod_q[j] <= '0;
          acc_q[j]  <= '0;
        end
      end else begin
        if (shift) begin
          a_line_q[0] <= in_a;
          for (int unsigned k = 1; k < MAX_LAGS; k++)   a_line_q[k] <= a_line_q[k-1];
          b_line_q[0] <= in_b;
          for (int unsigned k = 1; k < 2*MAX_LAGS; k++) b_line_q[k] <= b_line_q[k-1];
          for (int unsigned j = 0; j < NUM_LAGS; j++)   prod_q[j]   <= prod_d[j];
        end
        for (int unsigned j = 0; j < NUM_LAGS; j++) acc_q[j] <= acc_d[j];
      end
      if (load) begin
        for (int unsigned j = 0; j < NUM_LAGS; j++) xcorr_q[j] <= acc_d[j];
      end
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.s_ready    = (state_q == S_ACCUM);
  assign bus.iter_valid = (state_q == S_SCAN);
  assign bus.frame_done = (state_q == S_DONE);
  assign bus.iterator   = iter_q;
  assign bus.xcorr_out  = xcorr_q;
endmodule

// File: tb/tb_xcorr_lag_engine.sv
// Scoreboard bench for xcorr_lag_engine: a 16-sample instance for impulse, control,
// backpressure and reset cases, and a 1024-sample instance for full-scale data.
module tb_xcorr_lag_engine;
  localparam int NB = 12;
  localparam int NX = 34;
  localparam int M  = 17;
  localparam int NL = 2 * M + 1;
  localparam int N0 = 16;
  localparam int N1 = 1024;

  typedef logic signed [63:0] val_t;
  typedef val_t [NL-1:0]      vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  xcorr_lag_engine_if #(.NUM_BITS_SAMPLE(NB), .NUM_BITS_XCORRS(NX), .MAX_LAGS(M)) bus0 ();
  xcorr_lag_engine_if #(.NUM_BITS_SAMPLE(NB), .NUM_BITS_XCORRS(NX), .MAX_LAGS(M)) bus1 ();

  xcorr_lag_engine #(.NUM_BITS_SAMPLE(NB), .NUM_SAMPLES(N0), .NUM_BITS_XCORRS(NX), .MAX_LAGS(M))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  xcorr_lag_engine #(.NUM_BITS_SAMPLE(NB), .NUM_SAMPLES(N1), .NUM_BITS_XCORRS(NX), .MAX_LAGS(M))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t exp0_q[$];
  vec_t exp1_q[$];

  task automatic chk(input string name, input longint got, input longint want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: xcorr[j] = sum_n a[n]*b[n+M-j], out-of-range b contributes nothing.
  function automatic vec_t model(input int a[$], input int b[$]);
    vec_t r;
    int   ns, k;
    ns = a.size();
    for (int j = 0; j < NL; j++) begin
      r[j] = 0;
      for (int n = 0; n < ns; n++) begin
        k = n + M - j;
        if (k >= 0 && k < ns) r[j] += longint'(a[n]) * longint'(b[k]);
      end
    end
    return r;
  endfunction

  function automatic vec_t grab0();
    vec_t v;
    for (int j = 0; j < NL; j++) v[j] = $signed(bus0.xcorr_out[j]);
    return v;
  endfunction

  function automatic vec_t grab1();
    vec_t v;
    for (int j = 0; j < NL; j++) v[j] = $signed(bus1.xcorr_out[j]);
    return v;
  endfunction

  task automatic wait_idle0();
    int g;
    g = 0;
    while (bus0.busy && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (bus0.busy) chk("idle_timeout", 1, 0);
  endtask

  // mode 0: continuous valid, 1: valid toggles 1,0,1,0..., 2: random gaps
  task automatic drive0(input int a[$], input int b[$], input int mode);
    int i, g;
    bit ph, acc;
    i = 0; g = 0; ph = 1'b1;
    wait_idle0();
    exp0_q.push_back(model(a, b));
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    while (i < a.size() && g < 4 * N0 + 8) begin
      bus0.s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ph : ($urandom_range(3) != 0);
      bus0.s_a     = NB'(a[i]);
      bus0.s_b     = NB'(b[i]);
      @(negedge clk);
      acc = bus0.s_valid && bus0.s_ready;
      @(posedge clk); #1;
      if (acc) i++;
      g++;
      ph = !ph;
    end
    if (i != a.size()) chk("accept_timeout", i, a.size());
    bus0.s_valid = 1'b1;
    bus0.s_a     = '1;
    bus0.s_b     = '1;
    repeat (3) begin
      @(negedge clk);
      chk("extra_sample_ready", bus0.s_ready, 0);
      @(posedge clk); #1;
    end
    bus0.s_valid = 1'b0;
  endtask

  task automatic rand_frame(output int a[$], output int b[$]);
    a = {};
    b = {};
    for (int n = 0; n < N0; n++) begin
      a.push_back(int'($urandom_range(4095)) - 2048);
      b.push_back(int'($urandom_range(4095)) - 2048);
    end
  endtask

  initial begin : mon0
    vec_t last, cur;
    int   idx, gap;
    bit   in_scan, was_scan;
    last = '0; idx = 0; gap = 1000; in_scan = 1'b0; was_scan = 1'b0;
    forever begin
      @(negedge clk);
      gap++;
      if (!rst) begin
        chk("rst_outputs", {bus0.busy, bus0.s_ready, bus0.iter_valid, bus0.frame_done,
                            (bus0.iterator != 0), (bus0.xcorr_out != '0)}, 0);
        last = '0; in_scan = 1'b0; was_scan = 1'b0; gap = 1000;
      end else begin
        chk("frame_done", bus0.frame_done, was_scan && !bus0.iter_valid);
        if (was_scan && !bus0.iter_valid) begin
          chk("scan_len", idx, NL);
          chk("done_busy", bus0.busy, 1);
        end
        if (bus0.iter_valid) begin
          if (!in_scan) begin
            chk("latency", gap, M + 2);
            if (exp0_q.size() == 0) chk("unexpected_scan", 1, 0);
            else last = exp0_q.pop_front();
            cur = grab0();
            for (int j = 0; j < NL; j++) chk($sformatf("xcorr[%0d]", j), cur[j], last[j]);
            in_scan = 1'b1;
            idx = 0;
          end
          chk("iterator", bus0.iterator, idx);
          chk("scan_stable", grab0() == last, 1);
          idx++;
        end else begin
          in_scan = 1'b0;
          chk("iter_idle", bus0.iterator, 0);
          chk("xcorr_hold", grab0() == last, 1);
          if (!bus0.busy) chk("idle_ready", bus0.s_ready, 0);
        end
        was_scan = bus0.iter_valid;
        if (bus0.s_valid && bus0.s_ready) gap = 0;
      end
    end
  end

  initial begin : mon1
    vec_t e, g;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b0;
      end else begin
        if (bus1.iter_valid && !prev) begin
          if (exp1_q.size() == 0) begin
            chk("unexpected_scan1", 1, 0);
          end else begin
            e = exp1_q.pop_front();
            g = grab1();
            for (int j = 0; j < NL; j++) chk($sformatf("xcorr1[%0d]", j), g[j], e[j]);
            chk("xcorr1_lag0_full_scale", g[M], 64'sd4294967296);
            chk("xcorr1_edge_lag", g[0], longint'(N1 - M) * 64'sd4194304);
          end
        end
        prev = bus1.iter_valid;
      end
    end
  end

  initial begin : stim
    int a[$], b[$], imp[$], z[$];
    int g;
    bus0.start = 1'b0; bus0.s_valid = 1'b0; bus0.s_a = '0; bus0.s_b = '0;
    bus1.start = 1'b0; bus1.s_valid = 1'b0; bus1.s_a = '0; bus1.s_b = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < N0; n++) begin
      z.push_back(0);
      imp.push_back(n == 0 ? 100 : 0);
    end
    drive0(imp, imp, 0);
    a = z; b = z; a[5] = 100; b[8] = 100;
    drive0(a, b, 0);
    drive0(b, a, 0);
    drive0(imp, imp, 1);

    rand_frame(a, b);
    drive0(a, b, 2);
    g = 0;
    while (!bus0.iter_valid && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk("scan_reached", bus0.iter_valid, 1);
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;

    repeat (5) begin
      rand_frame(a, b);
      drive0(a, b, $urandom_range(2));
    end

    wait_idle0();
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start   = 1'b0;
    bus0.s_valid = 1'b1;
    for (int n = 0; n < 7; n++) begin
      bus0.s_a = NB'($urandom);
      bus0.s_b = NB'($urandom);
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    chk("async_rst", {bus0.busy, bus0.s_ready, bus0.iter_valid, bus0.frame_done,
                      (bus0.iterator != 0), (bus0.xcorr_out != '0)}, 0);
    bus0.s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_rst", bus0.busy, 0);
    rand_frame(a, b);
    drive0(a, b, 0);
    wait_idle0();

    a = {};
    for (int n = 0; n < N1; n++) a.push_back(-2048);
    exp1_q.push_back(model(a, a));
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start   = 1'b0;
    bus1.s_valid = 1'b1;
    bus1.s_a     = -12'sd2048;
    bus1.s_b     = -12'sd2048;
    repeat (N1) @(posedge clk);
    #1 bus1.s_valid = 1'b0;

    g = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0 || bus1.busy) && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    chk("scoreboard0_drained", exp0_q.size(), 0);
    chk("scoreboard1_drained", exp1_q.size(), 0);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
